// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_e   : arbiter FSM states
//   SEL_IF/SEL_LS : encoding of the datapath mux select and of the round-robin "last" owner
//   DEF_*         : default widths and timeout length
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_LS = 1'b1;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker.
//   req0_i/req1_i : requests (0 = IF, 1 = LS)
//   last_i        : previous winner (0 = requester 0, 1 = requester 1)
//   gnt0_o/gnt1_o : one-hot pick; on a tie the requester that did not win last time is chosen
module arb_rr2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = req0_i & (~req1_i | last_i);
  assign gnt1_o = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// Latches the winning request, holds it on mem_* until mem_ack, then returns the
// read data to the winner with a one-cycle rvalid pulse. All outputs are registered.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   if_*                : fetch request/grant/response
//   ls_*                : load/store request/grant/response (ls_rdata is 0 for stores)
//   mem_*               : unified memory handshake
//   sel_o               : datapath address/data mux select (0 = IF, 1 = LS)
// Optional macro ARB_TIMEOUT_EN adds a busy-cycle counter, the TIMEOUT_CYC parameter
// and the if_err_o/ls_err_o flags; without it BUSY waits for mem_ack indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wstrb_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
`ifdef ARB_TIMEOUT_EN
  output logic                ls_err_o,
  output logic                if_err_o,
`endif
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                sel_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_e         state_q, state_d;
  logic               last_q, last_d;
  logic               sel_q, sel_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [StrbW-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic               if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic               if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic               pick_if, pick_ls;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic               timeout;
  // The counter would reach TIMEOUT_CYC at this edge.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`endif

  arb_rr2 u_arb_rr2 (
    .req0_i (if_req_i),
    .req1_i (ls_req_i),
    .last_i (last_q),
    .gnt0_o (pick_if),
    .gnt1_o (pick_ls)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    if_err_d    = 1'b0;
    ls_err_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // mem_ack here is stray and deliberately ignored.
        if (pick_if) begin
          state_d     = BUSY_IF;
          last_d      = SEL_IF;
          sel_d       = SEL_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (pick_ls) begin
          state_d     = BUSY_LS;
          last_d      = SEL_LS;
          sel_d       = SEL_LS;
          ls_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
          mem_wstrb_d = ls_wstrb_i;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = '0;
            ls_err_d    = 1'b1;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = '0;
            if_err_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_q      <= SEL_IF;
      sel_q       <= SEL_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
`endif
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign sel_o       = sel_q;
`ifdef ARB_TIMEOUT_EN
  assign if_err_o    = if_err_q;
  assign ls_err_o    = ls_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed stimulus, a transaction-level
// reference model, and a negedge compare process, plus literal spot checks.
module tb_mem_port_arbiter;

  localparam int unsigned TbTo = 4;

  logic        clk, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wstrb;
  logic        mem_req, mem_we, mem_ack, sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef ARB_TIMEOUT_EN
  logic        if_err, ls_err;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic is_ls;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TbTo)
`endif
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .ls_req_i    (ls_req),
    .ls_we_i     (ls_we),
    .ls_addr_i   (ls_addr),
    .ls_wdata_i  (ls_wdata),
    .ls_wstrb_i  (ls_wstrb),
    .ls_gnt_o    (ls_gnt),
    .ls_rvalid_o (ls_rvalid),
    .ls_rdata_o  (ls_rdata),
`ifdef ARB_TIMEOUT_EN
    .ls_err_o    (ls_err),
    .if_err_o    (if_err),
`endif
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .sel_o       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (one transaction at a time) ----------------
  logic        m_busy, m_owner, m_last;
  int unsigned m_wait;
  logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_if_err, e_ls_err;
  logic        e_sel, e_mreq, e_we;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_ls_rdata;
  logic [3:0]  e_wstrb;
  logic        pick_ls;

  // Lone requester wins; on a tie the one that was not served last wins.
  assign pick_ls = (if_req && ls_req) ? ~m_last : ls_req;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b0; m_wait <= 0;
      e_if_gnt <= 1'b0; e_ls_gnt <= 1'b0; e_if_rv <= 1'b0; e_ls_rv <= 1'b0;
      e_if_err <= 1'b0; e_ls_err <= 1'b0; e_sel <= 1'b0; e_mreq <= 1'b0; e_we <= 1'b0;
      e_addr <= '0; e_wdata <= '0; e_wstrb <= '0; e_if_rdata <= '0; e_ls_rdata <= '0;
    end else begin
      e_if_gnt <= 1'b0; e_ls_gnt <= 1'b0; e_if_rv <= 1'b0; e_ls_rv <= 1'b0;
      e_if_err <= 1'b0; e_ls_err <= 1'b0;
      if (!m_busy) begin
        if (if_req || ls_req) begin
          m_busy   <= 1'b1;
          m_owner  <= pick_ls;
          m_last   <= pick_ls;
          m_wait   <= 0;
          e_sel    <= pick_ls;
          e_mreq   <= 1'b1;
          e_if_gnt <= ~pick_ls;
          e_ls_gnt <= pick_ls;
          e_we     <= pick_ls & ls_we;
          e_addr   <= pick_ls ? ls_addr : if_addr;
          e_wdata  <= ls_wdata;
          e_wstrb  <= pick_ls ? ls_wstrb : 4'h0;
        end
      end else if (mem_ack) begin
        m_busy <= 1'b0;
        e_mreq <= 1'b0;
        if (m_owner) begin
          e_ls_rv    <= 1'b1;
          e_ls_rdata <= e_we ? 32'h0 : mem_rdata;
        end else begin
          e_if_rv    <= 1'b1;
          e_if_rdata <= mem_rdata;
        end
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_wait + 1 == TbTo) begin
        m_busy <= 1'b0;
        e_mreq <= 1'b0;
        if (m_owner) begin
          e_ls_rv <= 1'b1; e_ls_rdata <= '0; e_ls_err <= 1'b1;
        end else begin
          e_if_rv <= 1'b1; e_if_rdata <= '0; e_if_err <= 1'b1;
        end
      end else begin
        m_wait <= m_wait + 1;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      check("ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
      check("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      check("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv));
      check("sel", 32'(sel), 32'(e_sel));
      check("mem_req", 32'(mem_req), 32'(e_mreq));
      check("if_rdata", if_rdata, e_if_rdata);
      check("ls_rdata", ls_rdata, e_ls_rdata);
      if (e_mreq) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (m_owner) check("mem_wdata", mem_wdata, e_wdata);
      end
`ifdef ARB_TIMEOUT_EN
      if (e_if_rv) check("if_err", 32'(if_err), 32'(e_if_err));
      if (e_ls_rv) check("ls_err", 32'(ls_err), 32'(e_ls_err));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic got_ls);
    got_ls = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_gnt || ls_gnt) begin
        got_ls = ls_gnt;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_gnt: got no grant in 10 cycles, expected a grant");
  endtask

  task automatic ack(input logic [31:0] d);
    mem_rdata = d;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
    ls_wdata = '0; ls_wstrb = '0; mem_ack = 0; mem_rdata = '0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);

    // 1: reset in the middle of a load, then a lone fetch
    ls_req = 1; ls_we = 0; ls_addr = 32'h2000_0000;
    wait_gnt(is_ls);
    check("t1_ls_won", 32'(is_ls), 32'h1);
    ls_req = 0;
    tick();
    check("t1_busy_req", 32'(mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_mem_req", 32'(mem_req), 32'h0);
    check("t1_rst_sel", 32'(sel), 32'h0);
    check("t1_rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    if_req = 1; if_addr = 32'h80;
    tick();
    check("t1_if_gnt", 32'(if_gnt), 32'h1);
    check("t1_sel", 32'(sel), 32'h0);
    if_req = 0;
    ack(32'h1234_5678);
    check("t1_if_rvalid", 32'(if_rvalid), 32'h1);
    tick();

    // 2: lone fetch, ack two cycles after the grant
    if_req = 1; if_addr = 32'h0000_0040;
    wait_gnt(is_ls);
    check("t2_if_won", 32'(is_ls), 32'h0);
    check("t2_addr", mem_addr, 32'h0000_0040);
    check("t2_we", 32'(mem_we), 32'h0);
    if_req = 0;
    tick();
    tick();
    check("t2_req_held", 32'(mem_req), 32'h1);
    ack(32'h00A0_0093);
    check("t2_rvalid", 32'(if_rvalid), 32'h1);
    check("t2_rdata", if_rdata, 32'h00A0_0093);
    tick();
    check("t2_rvalid_pulse", 32'(if_rvalid), 32'h0);
    check("t2_rdata_hold", if_rdata, 32'h00A0_0093);

    // 3: both requesting from the first cycle after reset -> LS, IF, LS, ...
    do_reset();
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(is_ls);
      check("t3_order", 32'(is_ls), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("t3_sel", 32'(sel), (i % 2 == 0) ? 32'h1 : 32'h0);
      ack(32'h100 + 32'(i));
      if (i == 1) check("t3_if_rdata", if_rdata, 32'h101);
      if (i == 5) begin
        if_req = 0; ls_req = 0;
      end
    end
    tick();
    check("t3_idle", 32'(mem_req), 32'h0);

    // 4: store with ack in the grant cycle
    ls_req = 1; ls_we = 1; ls_addr = 32'h1000_0004; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'hF;
    tick();
    check("t4_gnt", 32'(ls_gnt), 32'h1);
    check("t4_we", 32'(mem_we), 32'h1);
    check("t4_addr", mem_addr, 32'h1000_0004);
    check("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t4_wstrb", 32'(mem_wstrb), 32'hF);
    ls_req = 0;
    ack(32'hFFFF_FFFF);
    check("t4_rvalid", 32'(ls_rvalid), 32'h1);
    check("t4_rdata", ls_rdata, 32'h0);
    check("t4_req_drop", 32'(mem_req), 32'h0);
    ls_we = 0; ls_wstrb = '0;
    tick();

    // 5: stray ack while idle; LS request withdrawn while IF is busy
    ack(32'h55);
    check("t5_no_if_rv", 32'(if_rvalid), 32'h0);
    check("t5_no_ls_rv", 32'(ls_rvalid), 32'h0);
    check("t5_idle", 32'(mem_req), 32'h0);
    if_req = 1; if_addr = 32'h44;
    wait_gnt(is_ls);
    if_req = 0;
    ls_req = 1; ls_addr = 32'h3000;
    tick();
    tick();
    ls_req = 0;
    ack(32'h77);
    check("t5_if_rv", 32'(if_rvalid), 32'h1);
    tick();
    tick();
    check("t5_no_ls_gnt", 32'(ls_gnt), 32'h0);
    check("t5_still_idle", 32'(mem_req), 32'h0);

    // 6: memory never acks
    ls_req = 1; ls_we = 0; ls_addr = 32'h3000_0000;
    wait_gnt(is_ls);
    ls_req = 0;
`ifdef ARB_TIMEOUT_EN
    tick(); tick(); tick();
    check("t6_busy", 32'(mem_req), 32'h1);
    check("t6_no_rv_yet", 32'(ls_rvalid), 32'h0);
    tick();
    check("t6_rvalid", 32'(ls_rvalid), 32'h1);
    check("t6_err", 32'(ls_err), 32'h1);
    check("t6_rdata", ls_rdata, 32'h0);
    check("t6_req_drop", 32'(mem_req), 32'h0);
    ack(32'h99);
    check("t6_late_ack", 32'(ls_rvalid), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_req_held", 32'(mem_req), 32'h1);
    end
    ack(32'h99);
    check("t6_rvalid", 32'(ls_rvalid), 32'h1);
    check("t6_rdata", ls_rdata, 32'h99);
`endif
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
